// File: rtl/instruction_fetch.sv
// Multicycle fetch stage: holds the PC, reads one word per instruction
// from the bus and hands it to the decoder with a one-cycle valid pulse.
//
// Ports:
//   clk, reset        rising-edge clock, synchronous active-high reset
//   i_state           CPU phase, 0 = FETCH, 1 = EXECUTE
//   i_exec_done       execute finished; i_pc_we picks target vs PC+4
//   i_pc_next         branch/jump target (low two bits ignored)
//   o_bus_addr/read   read request, held until i_bus_ack
//   i_bus_data/ack    returned word and its one-cycle strobe
//   o_instr/o_valid   captured word and its one-cycle pulse
//   o_pc/o_pc_plus4   address of o_instr and that address plus four
//   o_fetch_err       sticky bus timeout flag
//
// Optional macro FETCH_TIMEOUT_EN adds a TIMEOUT_CYCLES bus-wait limit.
// Without it a fetch waits forever and o_fetch_err is tied low.

module instruction_fetch #(
  parameter logic [31:0] RESET_PC       = 32'h0000_0000,
  parameter int          TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_state,
  input  logic        i_exec_done,
  input  logic        i_pc_we,
  input  logic [31:0] i_pc_next,
  output logic [31:0] o_bus_addr,
  output logic        o_bus_read,
  input  logic [31:0] i_bus_data,
  input  logic        i_bus_ack,
  output logic [31:0] o_instr,
  output logic        o_valid,
  output logic [31:0] o_pc,
  output logic [31:0] o_pc_plus4,
  output logic        o_fetch_err
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_HOLD
  } state_t;

  localparam logic [31:0] LP_RST_PC =
    {RESET_PC[31:2], 2'b00};

  state_t      r_state;
  state_t      w_next;
  logic [31:0] r_pc;
  logic [31:0] r_instr;
  logic        r_valid;
  logic [31:0] w_pc_plus4;
  logic        w_ack;
  logic        w_done;
  logic        w_tmo;
  logic        w_unused;

  assign w_pc_plus4 = r_pc + 32'd4;
  assign w_ack      = (r_state == S_REQ) && i_bus_ack;
  assign w_done     = (r_state == S_HOLD) && i_exec_done;

  // Low target bits are always dropped to keep the PC word aligned.
  assign w_unused = ^i_pc_next[1:0];

`ifdef FETCH_TIMEOUT_EN
  localparam logic [15:0] LP_TERM =
    16'(TIMEOUT_CYCLES - 1);

  logic [15:0] r_cnt;
  logic        r_err;

  // r_cnt counts completed REQ cycles; on the Nth REQ cycle it
  // holds N-1, so the terminal cycle is the TIMEOUT_CYCLES-th one.
  // An ack on that cycle still wins.
  assign w_tmo = (r_state == S_REQ) && !i_bus_ack &&
                 (r_cnt == LP_TERM);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= '0;
      r_err <= 1'b0;
    end else begin
      if (r_state != S_REQ) begin
        r_cnt <= '0;
      end else if (!i_bus_ack) begin
        r_cnt <= r_cnt + 16'd1;
      end
      if (w_tmo) begin
        r_err <= 1'b1;
      end else if (w_done) begin
        r_err <= 1'b0;
      end
    end
  end

  assign o_fetch_err = r_err;
`else
  logic w_unused_cfg;

  assign w_tmo        = 1'b0;
  assign o_fetch_err  = 1'b0;
  assign w_unused_cfg = (TIMEOUT_CYCLES != 0);
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: if (!i_state) w_next = S_REQ;
      S_REQ:  if (w_ack || w_tmo) w_next = S_HOLD;
      S_HOLD: if (i_exec_done) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc    <= LP_RST_PC;
      r_instr <= '0;
      r_valid <= 1'b0;
    end else begin
      r_valid <= w_ack || w_tmo;
      if (w_ack) begin
        r_instr <= i_bus_data;
      end else if (w_tmo) begin
        r_instr <= '0;
      end
      if (w_done) begin
        r_pc <= i_pc_we ? {i_pc_next[31:2], 2'b00}
                        : w_pc_plus4;
      end
    end
  end

  assign o_bus_addr = r_pc;
  assign o_bus_read = (r_state == S_REQ);
  assign o_instr    = r_instr;
  assign o_valid    = r_valid;
  assign o_pc       = r_pc;
  assign o_pc_plus4 = w_pc_plus4;

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: fetch latency, PC update
// paths, wrap, ignored strobes, reset abort and optional timeout.

module tb_instruction_fetch;

  logic        clk;
  logic        reset;
  logic        i_state;
  logic        i_exec_done;
  logic        i_pc_we;
  logic [31:0] i_pc_next;
  logic [31:0] o_bus_addr;
  logic        o_bus_read;
  logic [31:0] i_bus_data;
  logic        i_bus_ack;
  logic [31:0] o_instr;
  logic        o_valid;
  logic [31:0] o_pc;
  logic [31:0] o_pc_plus4;
  logic        o_fetch_err;

  int checks   = 0;
  int failures = 0;

  instruction_fetch #(
    .RESET_PC      (32'h0000_0100),
    .TIMEOUT_CYCLES(4)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .i_state    (i_state),
    .i_exec_done(i_exec_done),
    .i_pc_we    (i_pc_we),
    .i_pc_next  (i_pc_next),
    .o_bus_addr (o_bus_addr),
    .o_bus_read (o_bus_read),
    .i_bus_data (i_bus_data),
    .i_bus_ack  (i_bus_ack),
    .o_instr    (o_instr),
    .o_valid    (o_valid),
    .o_pc       (o_pc),
    .o_pc_plus4 (o_pc_plus4),
    .o_fetch_err(o_fetch_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %h expected %h",
             tag, obs, exp);
    end
  endtask

  initial begin
    reset       = 1'b1;
    i_state     = 1'b0;
    i_exec_done = 1'b0;
    i_pc_we     = 1'b0;
    i_pc_next   = '0;
    i_bus_data  = '0;
    i_bus_ack   = 1'b0;

    // reset state
    tick();
    chk("rst_read", 32'(o_bus_read), 32'd0);
    chk("rst_valid", 32'(o_valid), 32'd0);
    chk("rst_instr", o_instr, 32'h0);
    chk("rst_pc", o_pc, 32'h100);
    chk("rst_err", 32'(o_fetch_err), 32'd0);
    reset = 1'b0;

    // first fetch, ack three cycles after request
    tick();
    chk("f1_read", 32'(o_bus_read), 32'd1);
    chk("f1_addr", o_bus_addr, 32'h100);
    tick();
    chk("f1_wait1", 32'(o_valid), 32'd0);
    tick();
    chk("f1_wait2", 32'(o_valid), 32'd0);
    chk("f1_held", 32'(o_bus_read), 32'd1);
    i_bus_ack  = 1'b1;
    i_bus_data = 32'h0050_0093;
    tick();
    i_bus_ack = 1'b0;
    chk("f1_valid", 32'(o_valid), 32'd1);
    chk("f1_instr", o_instr, 32'h0050_0093);
    chk("f1_rd_low", 32'(o_bus_read), 32'd0);
    chk("f1_plus4", o_pc_plus4, 32'h104);
    tick();
    chk("f1_pulse", 32'(o_valid), 32'd0);
    chk("f1_stable", o_instr, 32'h0050_0093);

    // sequential update
    i_exec_done = 1'b1;
    tick();
    i_exec_done = 1'b0;
    chk("seq_pc", o_pc, 32'h104);
    chk("seq_idle", 32'(o_bus_read), 32'd0);
    tick();
    chk("seq_read", 32'(o_bus_read), 32'd1);
    chk("seq_addr", o_bus_addr, 32'h104);

    // stray exec_done while in REQ
    i_exec_done = 1'b1;
    i_pc_we     = 1'b1;
    i_pc_next   = 32'h0000_0999;
    tick();
    i_exec_done = 1'b0;
    i_pc_we     = 1'b0;
    chk("strayd_pc", o_pc, 32'h104);
    chk("strayd_rd", 32'(o_bus_read), 32'd1);
    chk("strayd_vld", 32'(o_valid), 32'd0);
    i_bus_ack  = 1'b1;
    i_bus_data = 32'h0000_0013;
    tick();
    i_bus_ack = 1'b0;
    chk("f2_valid", 32'(o_valid), 32'd1);
    chk("f2_instr", o_instr, 32'h0000_0013);
    tick();
    chk("f2_pulse", 32'(o_valid), 32'd0);

    // redirect, then park in IDLE with i_state = EXECUTE
    i_exec_done = 1'b1;
    i_pc_we     = 1'b1;
    i_pc_next   = 32'h0000_0203;
    i_state     = 1'b1;
    tick();
    i_exec_done = 1'b0;
    i_pc_we     = 1'b0;
    chk("redir_addr", o_bus_addr, 32'h200);
    tick();
    chk("park_read", 32'(o_bus_read), 32'd0);

    // stray ack in IDLE
    i_bus_ack  = 1'b1;
    i_bus_data = 32'h0000_0bad;
    tick();
    i_bus_ack = 1'b0;
    chk("straya_vld", 32'(o_valid), 32'd0);
    chk("straya_ins", o_instr, 32'h0000_0013);
    chk("straya_pc", o_pc, 32'h200);
    i_state = 1'b0;
    tick();
    chk("f3_read", 32'(o_bus_read), 32'd1);
    chk("f3_addr", o_bus_addr, 32'h200);
    i_bus_ack  = 1'b1;
    i_bus_data = 32'h0000_0033;
    tick();
    i_bus_ack = 1'b0;
    chk("f3_valid", 32'(o_valid), 32'd1);

    // pc_we without exec_done
    i_pc_we   = 1'b1;
    i_pc_next = 32'h0000_0400;
    tick();
    i_pc_we = 1'b0;
    chk("we_only_pc", o_pc, 32'h200);

    // wrap at top of address space
    i_exec_done = 1'b1;
    i_pc_we     = 1'b1;
    i_pc_next   = 32'hFFFF_FFFF;
    tick();
    i_exec_done = 1'b0;
    i_pc_we     = 1'b0;
    chk("wrap_pc", o_pc, 32'hFFFF_FFFC);
    chk("wrap_plus4", o_pc_plus4, 32'h0);
    tick();
    i_bus_ack  = 1'b1;
    i_bus_data = 32'h0000_0011;
    tick();
    i_bus_ack = 1'b0;
    chk("wrap_valid", 32'(o_valid), 32'd1);
    i_exec_done = 1'b1;
    tick();
    i_exec_done = 1'b0;
    chk("wrap_newpc", o_pc, 32'h0);
    tick();
    chk("wrap_read", 32'(o_bus_read), 32'd1);
    chk("wrap_addr", o_bus_addr, 32'h0);

    // reset in the middle of a request
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mid_read", 32'(o_bus_read), 32'd0);
    chk("mid_pc", o_pc, 32'h100);
    chk("mid_valid", 32'(o_valid), 32'd0);
    chk("mid_instr", o_instr, 32'h0);
    tick();
    chk("mid_rereq", 32'(o_bus_read), 32'd1);

`ifdef FETCH_TIMEOUT_EN
    // timeout after four unacknowledged REQ cycles
    tick();
    tick();
    tick();
    chk("to_wait", 32'(o_bus_read), 32'd1);
    chk("to_novld", 32'(o_valid), 32'd0);
    tick();
    chk("to_rdlow", 32'(o_bus_read), 32'd0);
    chk("to_valid", 32'(o_valid), 32'd1);
    chk("to_instr", o_instr, 32'h0);
    chk("to_err", 32'(o_fetch_err), 32'd1);
    tick();
    chk("to_pulse", 32'(o_valid), 32'd0);
    chk("to_sticky", 32'(o_fetch_err), 32'd1);
    i_exec_done = 1'b1;
    tick();
    i_exec_done = 1'b0;
    chk("to_clr", 32'(o_fetch_err), 32'd0);
    chk("to_pc", o_pc, 32'h104);

    // ack on the terminal cycle wins
    tick();
    chk("tc_read", 32'(o_bus_read), 32'd1);
    tick();
    tick();
    tick();
    i_bus_ack  = 1'b1;
    i_bus_data = 32'h0000_0073;
    tick();
    i_bus_ack = 1'b0;
    chk("tc_valid", 32'(o_valid), 32'd1);
    chk("tc_instr", o_instr, 32'h0000_0073);
    chk("tc_err", 32'(o_fetch_err), 32'd0);
`else
    // no timeout: request stays up and no error appears
    for (int i = 0; i < 10; i++) tick();
    chk("nt_read", 32'(o_bus_read), 32'd1);
    chk("nt_valid", 32'(o_valid), 32'd0);
    chk("nt_err", 32'(o_fetch_err), 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
